alu_issue_stage: RTL
====================

// Module: alu_issue_stage
// PURPOSE
//   Producer side of the ALU operand/control interface. Decodes one RV32 instruction plus its
//   register-file read data into {ALUCtrl, data1, data2} and side-band control.
//   Holds them in a single ID/EX pipeline register with a valid/ready handshake on both sides.
//   Sits between the register-file read stage and the ALU.
// PARAMETERS
//   XLEN            32  operand width; the ALU operand ports are XLEN wide
//   ILLEGAL_AS_NOP  1   1: an unsupported instruction issues as NOP (ALUCtrl 000); 0: it is dropped (no out_valid)
// PORTS
//   clk_i          in   1     clock, rising edge
//   rst_i          in   1     synchronous reset, active-low
//   inst_i         in   32    instruction word
//   rs1_data_i     in   XLEN  register-file read data for rs1
//   rs2_data_i     in   XLEN  register-file read data for rs2
//   in_valid_i     in   1     upstream offers inst/rs data this cycle
//   in_ready_o     out  1     stage accepts this cycle
//   flush_i        in   1     kill the held entry and the offered entry
//   out_valid_o    out  1     registered entry valid
//   out_ready_i    in   1     ALU/EX side consumes this cycle
//   ALUCtrl_o      out  3     001 and, 010 xor, 011 sll, 100 add, 101 sub, 110 mul, 111 srai, 000 nop
//   data1_o        out  XLEN  ALU operand 1 (rs1_data)
//   data2_o        out  XLEN  ALU operand 2 (rs2_data or immediate)
//   store_data_o   out  XLEN  rs2_data, captured for sw
//   rd_o           out  5     destination register, inst[11:7]
//   reg_write_o    out  1     result is written back
//   mem_read_o     out  1     lw
//   mem_write_o    out  1     sw
//   illegal_o      out  1     held entry came from an unsupported encoding
// BEHAVIOUR
// - Reset (rst_i==0 at a clk edge): out_valid_o=0, ALUCtrl_o=000, all data/control outputs 0.
//   Reset dominates flush_i and the handshakes. Reset mid-transfer discards the held entry.
// - in_ready_o = !out_valid_o || out_ready_i (combinational). Accept = in_valid_i && in_ready_o.
// - Accept with !flush_i: at the next edge, out_valid_o=1 and the outputs hold the decode of the accepted inputs.
// - out_valid_o && out_ready_i && no accept: at the next edge, out_valid_o=0 and the outputs are unchanged.
// - out_valid_o && !out_ready_i: all outputs held stable (no change while stalled).
// - flush_i=1: at the next edge, out_valid_o=0. No accept is recorded that cycle, whatever in_valid_i is.
//   Data outputs may keep their old values.
// - Latency: 1 cycle from accept to out_valid_o. Throughput 1/cycle while out_ready_i=1.
// - Decode on opcode=inst[6:0], f3=inst[14:12], f7=inst[31:25]:
//   0110011: f7=0000000 with f3 111/100/001/000 -> and/xor/sll/add.
//            f7=0100000, f3=000 -> sub.  f7=0000001, f3=000 -> mul.  reg_write=1, data2=rs2.
//   0010011: f3=000 -> addi(100), data2=sext(inst[31:20]).
//            f3=101 with f7=0100000 -> srai(111), data2=zext(inst[24:20]).  reg_write=1.
//   0000011, f3=010 -> lw: add(100), data2=sext(inst[31:20]), mem_read=1, reg_write=1.
//   0100011, f3=010 -> sw: add(100), data2=sext({inst[31:25],inst[11:7]}), mem_write=1, reg_write=0.
//   inst=32'h00000013 (canonical nop) -> ALUCtrl 100 with reg_write=1 to x0; not illegal.
//   Anything else -> illegal=1, ALUCtrl=000, reg/mem writes 0, data1=data2=0 (ILLEGAL_AS_NOP=1);
//   with ILLEGAL_AS_NOP=0 it is accepted but leaves out_valid_o=0.
// - rd_o is always inst[11:7]; it is forced to 0 when reg_write_o=0.
// - sext extends from bit 11 to XLEN. No arithmetic is performed in this block.
// - Simultaneous flush_i and out_ready_i: flush wins; the entry counts as killed, not consumed.
// TESTING
//   add x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle ALUCtrl=100, data1=5, data2=7, rd=3, reg_write=1
//   srai x5,x6,4 (0x40435293), rs1=0x80000000 -> ALUCtrl=111, data2=4, reg_write=1, illegal=0
//   sw x2,-4(x1) (0xFE20AE23), rs2=0xAB -> ALUCtrl=100, data2=0xFFFFFFFC, store_data=0xAB, mem_write=1, rd=0
//   back-pressure: accept mul then hold out_ready=0 for 3 cycles -> in_ready=0, outputs bit-stable, then one handshake
//   flush while out_valid=1 and in_valid=1 -> next cycle out_valid=0, offered instruction never appears
//   inst=0xFFFFFFFF -> illegal=1, ALUCtrl=000; rst_i=0 during a stall -> out_valid=0, ALUCtrl=000 next edge

Source files
------------

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes an RV32 instruction and its register operands into ALU control,
// operands and side-band control, held in one pipeline register with valid/ready on both sides.
module alu_issue_stage #(
    parameter int unsigned XLEN           = 32,
    parameter bit          ILLEGAL_AS_NOP = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [2:0]      ALUCtrl_o,
    output logic [XLEN-1:0] data1_o,
    output logic [XLEN-1:0] data2_o,
    output logic [XLEN-1:0] store_data_o,
    output logic [4:0]      rd_o,
    output logic            reg_write_o,
    output logic            mem_read_o,
    output logic            mem_write_o,
    output logic            illegal_o
);

    localparam logic [2:0] ALU_NOP  = 3'b000;
    localparam logic [2:0] ALU_AND  = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_SLL  = 3'b011;
    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b101;
    localparam logic [2:0] ALU_MUL  = 3'b110;
    localparam logic [2:0] ALU_SRAI = 3'b111;

    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] shamt;

    assign opcode = inst_i[6:0];
    assign f3     = inst_i[14:12];
    assign f7     = inst_i[31:25];
    assign imm_i  = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
    assign imm_s  = {{(XLEN-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign shamt  = {{(XLEN-5){1'b0}}, inst_i[24:20]};

    logic [2:0]      dec_ctrl;
    logic [XLEN-1:0] dec_data1;
    logic [XLEN-1:0] dec_data2;
    logic [XLEN-1:0] dec_store;
    logic [4:0]      dec_rd;
    logic            dec_rw;
    logic            dec_mr;
    logic            dec_mw;
    logic            dec_illegal;

    always_comb begin
        dec_ctrl    = ALU_NOP;
        dec_data1   = '0;
        dec_data2   = '0;
        dec_store   = '0;
        dec_rw      = 1'b0;
        dec_mr      = 1'b0;
        dec_mw      = 1'b0;
        dec_illegal = 1'b1;
        case (opcode)
            OP_REG: begin
                dec_data2 = rs2_data_i;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b111:  begin dec_ctrl = ALU_AND; dec_illegal = 1'b0; end
                        3'b100:  begin dec_ctrl = ALU_XOR; dec_illegal = 1'b0; end
                        3'b001:  begin dec_ctrl = ALU_SLL; dec_illegal = 1'b0; end
                        3'b000:  begin dec_ctrl = ALU_ADD; dec_illegal = 1'b0; end
                        default: dec_illegal = 1'b1;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    dec_ctrl    = ALU_SUB;
                    dec_illegal = 1'b0;
                end else if (f7 == 7'b0000001 && f3 == 3'b000) begin
                    dec_ctrl    = ALU_MUL;
                    dec_illegal = 1'b0;
                end
                dec_rw = !dec_illegal;
            end
            OP_IMM: begin
                // canonical nop 0x00000013 is addi x0,x0,0 and decodes here naturally
                if (f3 == 3'b000) begin
                    dec_ctrl    = ALU_ADD;
                    dec_data2   = imm_i;
                    dec_rw      = 1'b1;
                    dec_illegal = 1'b0;
                end else if (f3 == 3'b101 && f7 == 7'b0100000) begin
                    dec_ctrl    = ALU_SRAI;
                    dec_data2   = shamt;
                    dec_rw      = 1'b1;
                    dec_illegal = 1'b0;
                end
            end
            OP_LOAD: begin
                if (f3 == 3'b010) begin
                    dec_ctrl    = ALU_ADD;
                    dec_data2   = imm_i;
                    dec_mr      = 1'b1;
                    dec_rw      = 1'b1;
                    dec_illegal = 1'b0;
                end
            end
            OP_STORE: begin
                if (f3 == 3'b010) begin
                    dec_ctrl    = ALU_ADD;
                    dec_data2   = imm_s;
                    dec_store   = rs2_data_i;
                    dec_mw      = 1'b1;
                    dec_illegal = 1'b0;
                end
            end
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_ctrl  = ALU_NOP;
            dec_data2 = '0;
            dec_store = '0;
            dec_rw    = 1'b0;
            dec_mr    = 1'b0;
            dec_mw    = 1'b0;
        end else begin
            dec_data1 = rs1_data_i;
        end
        dec_rd = dec_rw ? inst_i[11:7] : 5'd0;
    end

    logic            valid_q,    valid_d;
    logic [2:0]      ctrl_q,     ctrl_d;
    logic [XLEN-1:0] data1_q,    data1_d;
    logic [XLEN-1:0] data2_q,    data2_d;
    logic [XLEN-1:0] store_q,    store_d;
    logic [4:0]      rd_q,       rd_d;
    logic            rw_q,       rw_d;
    logic            mr_q,       mr_d;
    logic            mw_q,       mw_d;
    logic            illegal_q,  illegal_d;
    logic            accept;
    logic            issue;

    assign in_ready_o = !valid_q || out_ready_i;
    assign accept     = in_valid_i && in_ready_o && !flush_i;
    assign issue      = !dec_illegal || ILLEGAL_AS_NOP;

    always_comb begin
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        data1_d   = data1_q;
        data2_d   = data2_q;
        store_d   = store_q;
        rd_d      = rd_q;
        rw_d      = rw_q;
        mr_d      = mr_q;
        mw_d      = mw_q;
        illegal_d = illegal_q;
        // flush wins over both consume and accept
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = issue;
            if (issue) begin
                ctrl_d    = dec_ctrl;
                data1_d   = dec_data1;
                data2_d   = dec_data2;
                store_d   = dec_store;
                rd_d      = dec_rd;
                rw_d      = dec_rw;
                mr_d      = dec_mr;
                mw_d      = dec_mw;
                illegal_d = dec_illegal;
            end
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_q   <= 1'b0;
            ctrl_q    <= ALU_NOP;
            data1_q   <= '0;
            data2_q   <= '0;
            store_q   <= '0;
            rd_q      <= '0;
            rw_q      <= 1'b0;
            mr_q      <= 1'b0;
            mw_q      <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            data1_q   <= data1_d;
            data2_q   <= data2_d;
            store_q   <= store_d;
            rd_q      <= rd_d;
            rw_q      <= rw_d;
            mr_q      <= mr_d;
            mw_q      <= mw_d;
            illegal_q <= illegal_d;
        end
    end

    assign out_valid_o  = valid_q;
    assign ALUCtrl_o    = ctrl_q;
    assign data1_o      = data1_q;
    assign data2_o      = data2_q;
    assign store_data_o = store_q;
    assign rd_o         = rd_q;
    assign reg_write_o  = rw_q;
    assign mem_read_o   = mr_q;
    assign mem_write_o  = mw_q;
    assign illegal_o    = illegal_q;

endmodule
